// File: rtl/elixirchip_es1_spu_op_logic_acc.sv
// elixirchip_es1_spu_op_logic_acc
//   Logic reduction accumulator placed after the SPU bitwise op units.
//   It folds every valid s_data since the last clear into a running
//   AND/OR/XOR accumulator and counts the folded elements. The result is
//   presented through a cke-gated pipeline that is LATENCY stages deep.
//
// Optional feature macro: ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
//   When it is defined, the block adds the m_parity output, which is the
//   XOR-reduction of the accumulator value and is aligned with m_data.
//
// Ports:
//   reset       in   asynchronous reset, active-low
//   clk         in   clock
//   cke         in   clock enable for every register in the block
//   s_data      in   operand from the upstream op stage
//   s_clear     in   restarts the accumulation
//   s_valid     in   s_data is a valid element to fold
//   m_data      out  accumulator value
//   m_count     out  number of elements folded since the last clear (saturating)
//   m_overflow  out  sticky flag that is set once the counter has saturated
//   m_valid     out  s_valid delayed so that it lines up with m_data
//   m_parity    out  (optional) parity of m_data

module elixirchip_es1_spu_op_logic_acc #(
   parameter int unsigned LATENCY    = 1,
   parameter int unsigned DATA_BITS  = 8,
   parameter type         data_t     = logic [DATA_BITS-1:0],
   parameter string       OP         = "AND",
   parameter data_t       CLEAR_DATA = '1,
   parameter int unsigned COUNT_BITS = 16,
   parameter string       DEVICE     = "RTL",
   parameter string       SIMULATION = "false",
   parameter string       DEBUG      = "false"
) (
   input  logic                  reset,
   input  logic                  clk,
   input  logic                  cke,
   input  data_t                 s_data,
   input  logic                  s_clear,
   input  logic                  s_valid,
   output data_t                 m_data,
   output logic [COUNT_BITS-1:0] m_count,
   output logic                  m_overflow,
   output logic                  m_valid
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
   ,
   output logic                  m_parity
`endif
);

   // Elaboration-time parameter checks
   if (LATENCY < 1) begin : g_bad_latency
      $error("LATENCY must be >= 1");
   end
   if (COUNT_BITS < 1) begin : g_bad_count_bits
      $error("COUNT_BITS must be >= 1");
   end
   if (DEVICE == "") begin : g_bad_device
      $error("DEVICE must name a target device");
   end
   if (SIMULATION != "true" && SIMULATION != "false") begin : g_bad_simulation
      $error("SIMULATION must be \"true\" or \"false\"");
   end
   if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
      $error("DEBUG must be \"true\" or \"false\"");
   end

   // Pipeline registers: index 0 holds the live accumulator, and the last index drives the outputs
   data_t                 acc_q [LATENCY];
   data_t                 acc_d [LATENCY];
   logic [COUNT_BITS-1:0] cnt_q [LATENCY];
   logic [COUNT_BITS-1:0] cnt_d [LATENCY];
   logic                  ovf_q [LATENCY];
   logic                  ovf_d [LATENCY];
   logic                  vld_q [LATENCY];
   logic                  vld_d [LATENCY];
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
   logic                  par_q [LATENCY];
   logic                  par_d [LATENCY];
`endif

   // Fold operator, selected when the design is elaborated
   data_t fold_c;

   if (OP == "AND") begin : g_op_and
      assign fold_c = acc_q[0] & s_data;
   end else if (OP == "OR") begin : g_op_or
      assign fold_c = acc_q[0] | s_data;
   end else if (OP == "XOR") begin : g_op_xor
      assign fold_c = acc_q[0] ^ s_data;
   end else begin : g_op_bad
      $error("OP must be \"AND\", \"OR\" or \"XOR\"");
      assign fold_c = acc_q[0];
   end

   // Next state: stage-0 accumulation and a shift through the later stages, both gated by cke
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      vld_d = vld_q;
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
      par_d = par_q;
`endif
      if (cke) begin
         if (s_clear) begin
            // A clear that arrives with a valid element restarts the fold from that element
            acc_d[0] = s_valid ? s_data : CLEAR_DATA;
            cnt_d[0] = s_valid ? COUNT_BITS'(1) : '0;
            ovf_d[0] = 1'b0;
         end else if (s_valid) begin
            acc_d[0] = fold_c;
            // The counter saturates instead of wrapping, and the overflow flag stays set until a clear
            if (&cnt_q[0]) begin
               ovf_d[0] = 1'b1;
            end else begin
               cnt_d[0] = cnt_q[0] + COUNT_BITS'(1);
            end
         end
         vld_d[0] = s_valid;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            acc_d[i] = acc_q[i-1];
            cnt_d[i] = cnt_q[i-1];
            ovf_d[i] = ovf_q[i-1];
            vld_d[i] = vld_q[i-1];
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
            par_d[i] = par_q[i-1];
`endif
         end
      end
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
      // Parity is taken from the next accumulator value, so it stays in step with acc when cke is low
      par_d[0] = ^acc_d[0];
`endif
   end

   // State registers; reset loads every stage with the cleared state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            acc_q[i] <= CLEAR_DATA;
            cnt_q[i] <= '0;
            ovf_q[i] <= 1'b0;
            vld_q[i] <= 1'b0;
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
            par_q[i] <= ^CLEAR_DATA;
`endif
         end
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         vld_q <= vld_d;
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
         par_q <= par_d;
`endif
      end
   end

   assign m_data     = acc_q[LATENCY-1];
   assign m_count    = cnt_q[LATENCY-1];
   assign m_overflow = ovf_q[LATENCY-1];
   assign m_valid    = vld_q[LATENCY-1];
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
   assign m_parity   = par_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_elixirchip_es1_spu_op_logic_acc.sv
// Testbench for elixirchip_es1_spu_op_logic_acc.
//   dut_a : AND, CLEAR_DATA=FF, COUNT_BITS=2, LATENCY=1
//   dut_x : XOR, CLEAR_DATA=00, LATENCY=1
//   dut_o : OR,  CLEAR_DATA=00, LATENCY=1
//   dut_l : AND, CLEAR_DATA=FF, LATENCY=3, random cke, compared against a model

module tb_elixirchip_es1_spu_op_logic_acc;

   logic       clk = 1'b0;
   logic       reset;
   logic       cke;
   logic       cke_l;
   logic [7:0] s_data;
   logic       s_clear;
   logic       s_valid;

   logic [7:0]  a_data, x_data, o_data, l_data;
   logic [1:0]  a_cnt;
   logic [15:0] x_cnt, o_cnt, l_cnt;
   logic        a_ovf, x_ovf, o_ovf, l_ovf;
   logic        a_vld, x_vld, o_vld, l_vld;
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
   logic        a_par, x_par, o_par, l_par;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   elixirchip_es1_spu_op_logic_acc #(.LATENCY(1), .DATA_BITS(8), .OP("AND"), .CLEAR_DATA(8'hFF), .COUNT_BITS(2)) dut_a (
      .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(a_data), .m_count(a_cnt), .m_overflow(a_ovf), .m_valid(a_vld)
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
      , .m_parity(a_par)
`endif
   );

   elixirchip_es1_spu_op_logic_acc #(.LATENCY(1), .DATA_BITS(8), .OP("XOR"), .CLEAR_DATA(8'h00), .COUNT_BITS(16)) dut_x (
      .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(x_data), .m_count(x_cnt), .m_overflow(x_ovf), .m_valid(x_vld)
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
      , .m_parity(x_par)
`endif
   );

   elixirchip_es1_spu_op_logic_acc #(.LATENCY(1), .DATA_BITS(8), .OP("OR"), .CLEAR_DATA(8'h00), .COUNT_BITS(16)) dut_o (
      .reset(reset), .clk(clk), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(o_data), .m_count(o_cnt), .m_overflow(o_ovf), .m_valid(o_vld)
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
      , .m_parity(o_par)
`endif
   );

   elixirchip_es1_spu_op_logic_acc #(.LATENCY(3), .DATA_BITS(8), .OP("AND"), .CLEAR_DATA(8'hFF), .COUNT_BITS(16)) dut_l (
      .reset(reset), .clk(clk), .cke(cke_l), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(l_data), .m_count(l_cnt), .m_overflow(l_ovf), .m_valid(l_vld)
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
      , .m_parity(l_par)
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Apply one set of inputs, then sample 1 time unit after the rising edge
   task automatic cyc(input logic c, input logic v, input logic [7:0] d);
      s_clear = c;
      s_valid = v;
      s_data  = d;
      @(posedge clk);
      #1;
   endtask

   // Reference model for dut_l: the stage-0 state plus a 3-deep delay line
   logic [7:0]  md [3];
   logic [15:0] mc [3];
   logic        mo [3];
   logic        mv [3];

   initial begin : main
      logic [7:0]  n_d;
      logic [15:0] n_c;
      logic        n_o;
      logic [1:0]  sat_cnt [4];
      logic        sat_ovf [4];

      sat_cnt[0] = 2'd1; sat_cnt[1] = 2'd2; sat_cnt[2] = 2'd3; sat_cnt[3] = 2'd3;
      sat_ovf[0] = 1'b0; sat_ovf[1] = 1'b0; sat_ovf[2] = 1'b0; sat_ovf[3] = 1'b1;

      reset = 1'b0; cke = 1'b1; cke_l = 1'b1;
      s_clear = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      #12;
      check("rst_a_data", 32'(a_data), 32'h00FF);
      check("rst_a_cnt",  32'(a_cnt),  32'h0);
      check("rst_a_ovf",  32'(a_ovf),  32'h0);
      check("rst_a_vld",  32'(a_vld),  32'h0);
      check("rst_x_data", 32'(x_data), 32'h0);
      check("rst_l_data", 32'(l_data), 32'h00FF);
      check("rst_l_vld",  32'(l_vld),  32'h0);
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
      check("rst_a_par",  32'(a_par),  32'h0);
`endif
      @(posedge clk); #1;
      reset = 1'b1;

      // AND fold
      cyc(1'b1, 1'b0, 8'h00);
      check("and_d0", 32'(a_data), 32'hFF); check("and_c0", 32'(a_cnt), 32'd0); check("and_v0", 32'(a_vld), 32'd0);
      cyc(1'b0, 1'b1, 8'hF0);
      check("and_d1", 32'(a_data), 32'hF0); check("and_c1", 32'(a_cnt), 32'd1); check("and_v1", 32'(a_vld), 32'd1);
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
      check("and_p1", 32'(a_par), 32'd0);
`endif
      cyc(1'b0, 1'b1, 8'h3C);
      check("and_d2", 32'(a_data), 32'h30); check("and_c2", 32'(a_cnt), 32'd2); check("and_v2", 32'(a_vld), 32'd1);

      // A clear that arrives together with a valid element
      cyc(1'b1, 1'b1, 8'hA5);
      check("clrv_d", 32'(a_data), 32'hA5); check("clrv_c", 32'(a_cnt), 32'd1);
      check("clrv_o", 32'(a_ovf), 32'd0);   check("clrv_v", 32'(a_vld), 32'd1);

      // Saturation with COUNT_BITS=2
      cyc(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b1, 8'hFF);
         check($sformatf("sat_c%0d", k), 32'(a_cnt), 32'(sat_cnt[k]));
         check($sformatf("sat_o%0d", k), 32'(a_ovf), 32'(sat_ovf[k]));
      end
      cyc(1'b1, 1'b0, 8'h00);
      check("satclr_c", 32'(a_cnt), 32'd0); check("satclr_o", 32'(a_ovf), 32'd0);
      check("satclr_d", 32'(a_data), 32'hFF);

      // XOR fold
      cyc(1'b1, 1'b0, 8'h00);
      check("xor_d0", 32'(x_data), 32'h00);
      cyc(1'b0, 1'b1, 8'h0F); check("xor_d1", 32'(x_data), 32'h0F);
      cyc(1'b0, 1'b1, 8'h0F); check("xor_d2", 32'(x_data), 32'h00);
      cyc(1'b0, 1'b1, 8'h01); check("xor_d3", 32'(x_data), 32'h01);
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
      check("xor_p3", 32'(x_par), 32'd1);
`endif

      // OR fold, followed by an idle cycle in which everything holds
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 8'h01); check("or_d1", 32'(o_data), 32'h01);
      cyc(1'b0, 1'b1, 8'h80); check("or_d2", 32'(o_data), 32'h81);
      cyc(1'b0, 1'b0, 8'h55);
      check("idle_d", 32'(o_data), 32'h81); check("idle_c", 32'(o_cnt), 32'd2); check("idle_v", 32'(o_vld), 32'd0);

      // When cke is low, dut_a (state 00, count 2) must ignore its inputs
      cyc(1'b0, 1'b1, 8'h33);
      check("pre_d", 32'(a_data), 32'h00); check("pre_c", 32'(a_cnt), 32'd3); check("pre_v", 32'(a_vld), 32'd1);
      cke = 1'b0;
      cyc(1'b1, 1'b0, 8'hAA);
      check("cke0_d", 32'(a_data), 32'h00); check("cke0_c", 32'(a_cnt), 32'd3); check("cke0_v", 32'(a_vld), 32'd1);
      cke = 1'b1;

      // Asynchronous reset in the middle of an accumulation
      cyc(1'b1, 1'b1, 8'h5A);
      check("mid_pre", 32'(a_data), 32'h5A);
      #2 reset = 1'b0;
      #1;
      check("arst_d", 32'(a_data), 32'hFF); check("arst_c", 32'(a_cnt), 32'd0);
      check("arst_o", 32'(a_ovf), 32'd0);   check("arst_v", 32'(a_vld), 32'd0);
      check("arst_ld", 32'(l_data), 32'hFF); check("arst_lc", 32'(l_cnt), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Random-cke run on the LATENCY=3 instance
      for (int i = 0; i < 3; i++) begin
         md[i] = 8'hFF; mc[i] = 16'd0; mo[i] = 1'b0; mv[i] = 1'b0;
      end
      n_d = 8'hFF; n_c = 16'd0; n_o = 1'b0;
      for (int t = 0; t < 400; t++) begin
         cke_l = ($urandom_range(0, 9) != 0);
         cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), 8'($urandom()));
         if (cke_l) begin
            if (s_clear) begin
               n_d = s_valid ? s_data : 8'hFF;
               n_c = s_valid ? 16'd1 : 16'd0;
               n_o = 1'b0;
            end else if (s_valid) begin
               n_d = n_d & s_data;
               if (n_c == 16'hFFFF) n_o = 1'b1;
               else n_c = n_c + 16'd1;
            end
            md[2] = md[1]; mc[2] = mc[1]; mo[2] = mo[1]; mv[2] = mv[1];
            md[1] = md[0]; mc[1] = mc[0]; mo[1] = mo[0]; mv[1] = mv[0];
            md[0] = n_d;   mc[0] = n_c;   mo[0] = n_o;   mv[0] = s_valid;
         end
         check($sformatf("lat_d t=%0d cke=%0d", t, cke_l), 32'(l_data), 32'(md[2]));
         check($sformatf("lat_c t=%0d cke=%0d", t, cke_l), 32'(l_cnt),  32'(mc[2]));
         check($sformatf("lat_o t=%0d cke=%0d", t, cke_l), 32'(l_ovf),  32'(mo[2]));
         check($sformatf("lat_v t=%0d cke=%0d", t, cke_l), 32'(l_vld),  32'(mv[2]));
`ifdef ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN
         check($sformatf("lat_p t=%0d", t), 32'(l_par), 32'(^md[2]));
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/elixirchip_es1_spu_op_logic_acc.md
Name: elixirchip_es1_spu_op_logic_acc

Overview:
Logic reduction accumulator that sits directly downstream of the SPU bitwise op units (nand/and/or/xor). It consumes their m_data results and folds them into a running accumulator: AND, OR or XOR is applied over every valid result since the last clear. It also counts the folded elements and presents the result through a cke-gated output pipeline of selectable latency.

Parameters:
LATENCY, 1, total pipeline depth from input to m_* outputs in cke-enabled cycles; legal range >=1.
DATA_BITS, 8, data width.
data_t, logic [DATA_BITS-1:0], data type.
OP, "AND", fold operator: "AND", "OR" or "XOR"; any other value is an elaboration error.
CLEAR_DATA, '1, accumulator value after clear and after reset.
COUNT_BITS, 16, element counter width; legal range >=1.
DEVICE, "RTL", device name.
SIMULATION, "false", simulation flag.
DEBUG, "false", debug flag.

Ports:
reset  input  1  reset, asynchronous, active-low (0 = asserted)
clk  input  1  clock
cke  input  1  clock enable; gates every register in the block
s_data  input  DATA_BITS  operand from the upstream op stage
s_clear  input  1  restart the accumulation
s_valid  input  1  s_data is a valid element to fold
m_data  output  DATA_BITS  accumulator value
m_count  output  COUNT_BITS  number of elements folded since the last clear
m_overflow  output  1  sticky flag: the counter has saturated
m_valid  output  1  s_valid delayed to align with m_data

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately regardless of cke):
  - acc=CLEAR_DATA, count=0, overflow=0.
  - All pipeline stages load the same values, with valid=0.
  - Outputs therefore read m_data=CLEAR_DATA, m_count=0, m_overflow=0, m_valid=0.
  - Reset asserted mid-accumulation discards all state.
- cke=0: every register holds; inputs are ignored that cycle.
- Stage 0 update on a clk edge with cke=1, priority top-down:
  - s_clear=1, s_valid=1: acc<=s_data, count<=1, overflow<=0.
  - s_clear=1, s_valid=0: acc<=CLEAR_DATA, count<=0, overflow<=0.
  - s_clear=0, s_valid=1: acc<=acc OP s_data (bitwise). If count is all-ones, count holds and overflow<=1; otherwise count<=count+1.
  - s_clear=0, s_valid=0: everything holds.
- Stage-0 valid register <= s_valid. The clear itself is not forwarded as valid.
- Pipeline: LATENCY-1 further register stages after stage 0 carry {acc, count, overflow, valid}, all cke-gated.
  - LATENCY=1: outputs are driven directly from the stage-0 registers.
  - An input sampled on an enabled edge appears at m_* after LATENCY enabled edges.
- No backpressure: the block always accepts input when cke=1.
- Count saturation: the counter never wraps. overflow stays 1 until the next clear or reset.
- Wrap of the data path is not applicable; the bitwise ops are width-preserving.

Optional Feature:
Macro ELIXIRCHIP_ES1_SPU_OP_LOGIC_ACC_PARITY_EN.
- Defined:
  - Adds port m_parity (output, 1 bit) = XOR-reduction of the acc value.
  - It is registered at stage 0 alongside acc and carried through the same pipeline, so it is always aligned with m_data.
  - Reset value is the parity of CLEAR_DATA.
- Not defined: the m_parity port and its registers do not exist; all other behaviour is identical.

Test Plan:
- Reset check (DATA_BITS=8, OP="AND", CLEAR_DATA=8'hFF, LATENCY=1):
  - Drive reset=0 asynchronously during accumulation -> same cycle m_data=8'hFF, m_count=0, m_overflow=0, m_valid=0.
- AND fold, cke=1:
  - Inputs: clear, then valid 8'hF0, then valid 8'h3C.
  - Expect m_data 8'hFF, 8'hF0, 8'h30; m_count 0, 1, 2; m_valid 0, 1, 1.
- Simultaneous clear+valid with s_data=8'hA5 after prior accumulation -> next cycle m_data=8'hA5, m_count=1, m_overflow=0.
- OR/XOR variants:
  - OP="XOR", CLEAR_DATA=0, valid 8'h0F, 8'h0F, 8'h01 -> m_data 8'h0F, 8'h00, 8'h01.
  - OP="OR", valid 8'h01, 8'h80 -> 8'h81.
- Saturation (COUNT_BITS=2):
  - 4 consecutive valids after a clear -> m_count 1, 2, 3, 3 and m_overflow rises on the 4th element.
  - A following clear -> m_count=0, m_overflow=0.
- Latency and cke (LATENCY=3, random cke ~90% high):
  - Outputs equal a reference model delayed by exactly 3 enabled edges.
  - Outputs stay stable across every cke=0 cycle.
  - With PARITY_EN defined, m_parity equals ^m_data on every cycle.
